// File: rtl/capture_pkg.sv
// Shared definitions for the capture data path: source mode codes and
// default maximal-length LFSR feedback masks for the legal sample widths.
package capture_pkg;

  typedef enum logic [1:0] {
    MODE_ADC   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } modeT;

  // Fibonacci masks, bit k set means stage k+1 feeds the XOR.
  function automatic logic [15:0] defaultLfsrTaps(input int width);
    case (width)
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// Left-shifting Fibonacci LFSR seeded with all-ones. The restart input also
// redirects the presented value to the seed in the same cycle.
module pattern_lfsr
  import capture_pkg::*;
#(
  parameter int           W    = 10,
  parameter logic [W-1:0] TAPS = W'(defaultLfsrTaps(W))
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         advance,
  input  logic         restart,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] Seed = '1;

  logic [W-1:0] state;
  logic [W-1:0] base;

  assign base  = restart ? Seed : state;
  assign value = base;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= Seed;
    end else if (advance) begin
      state <= {base[W-2:0], ^(base & TAPS)};
    end else if (restart) begin
      state <= Seed;
    end
  end

endmodule

// File: rtl/sample_source.sv
// Capture data source: two-stage pipeline selecting live ADC, ramp, LFSR or
// constant samples, with sync markers and a saturating ADC clip counter.
module sample_source
  import capture_pkg::*;
#(
  parameter int                    DATA_WIDTH = 10,
  parameter int                    RAMP_MAX   = 1020,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(defaultLfsrTaps(DATA_WIDTH)),
  parameter int                    CLIP_CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  nReset,
  input  logic [DATA_WIDTH-1:0] adc_databus,
  input  logic [1:0]            mode,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] constValue,
  input  logic                  clipClear,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  syncFlag,
  output logic [CLIP_CNT_W-1:0] clipCount
);

  if (DATA_WIDTH < 8 || DATA_WIDTH > 16) begin : gBadWidth
    $error("sample_source: DATA_WIDTH must be 8..16");
  end
  if (RAMP_MAX < 1 || RAMP_MAX > (2 ** DATA_WIDTH) - 1) begin : gBadRamp
    $error("sample_source: RAMP_MAX out of range for DATA_WIDTH");
  end
  if (LFSR_TAPS == '0) begin : gBadTaps
    $error("sample_source: LFSR_TAPS must be non-zero");
  end

  localparam logic [DATA_WIDTH-1:0] RampMax = DATA_WIDTH'(RAMP_MAX);

  logic [DATA_WIDTH-1:0] adcS1, constS1;
  modeT                  modeS1, modePrev;
  logic                  enS1;
  logic [DATA_WIDTH-1:0] ramp, rampBase, lfsrValue, sampleMux;
  logic                  rampWrapped, syncPending;
  logic                  modeChanged, rampRestart, rampAdvance;
  logic                  lfsrRestart, lfsrAdvance, isClip, syncNext;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      adcS1   <= '0;
      constS1 <= '0;
      modeS1  <= MODE_ADC;
      enS1    <= 1'b0;
    end else begin
      adcS1   <= adc_databus;
      constS1 <= constValue;
      modeS1  <= modeT'(mode);
      enS1    <= enable;
    end
  end

  pattern_lfsr #(.W(DATA_WIDTH), .TAPS(LFSR_TAPS)) uLfsr (
    .clock   (clock),
    .nReset  (nReset),
    .advance (lfsrAdvance),
    .restart (lfsrRestart),
    .value   (lfsrValue)
  );

  always_comb begin
    modeChanged = (modeS1 != modePrev);
    rampRestart = modeChanged && (modeS1 == MODE_RAMP);
    rampAdvance = enS1 && (modeS1 == MODE_RAMP);
    lfsrRestart = modeChanged && (modeS1 == MODE_LFSR);
    lfsrAdvance = enS1 && (modeS1 == MODE_LFSR);
    rampBase    = rampRestart ? '0 : ramp;
    isClip      = (adcS1 == '0) || (adcS1 == '1);
    sampleMux   = adcS1;
    case (modeS1)
      MODE_ADC:   sampleMux = adcS1;
      MODE_RAMP:  sampleMux = rampBase;
      MODE_LFSR:  sampleMux = lfsrValue;
      MODE_CONST: sampleMux = constS1;
      default:    sampleMux = adcS1;
    endcase
    // A restart already flags the first sample, so a stale wrap flag is harmless.
    syncNext = modeChanged || syncPending || ((modeS1 == MODE_RAMP) && rampWrapped);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      dataOut     <= '0;
      dataValid   <= 1'b0;
      syncFlag    <= 1'b0;
      modePrev    <= MODE_ADC;
      syncPending <= 1'b0;
      ramp        <= '0;
      rampWrapped <= 1'b0;
    end else begin
      modePrev  <= modeS1;
      dataValid <= enS1;
      if (enS1) begin
        dataOut     <= sampleMux;
        syncFlag    <= syncNext;
        syncPending <= 1'b0;
      end else begin
        syncFlag <= 1'b0;
        if (modeChanged) syncPending <= 1'b1;
      end
      if (rampAdvance) begin
        ramp        <= (rampBase == RampMax) ? '0 : rampBase + DATA_WIDTH'(1);
        rampWrapped <= (rampBase == RampMax);
      end else if (rampRestart) begin
        ramp        <= '0;
        rampWrapped <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      clipCount <= '0;
    end else if (clipClear) begin
      clipCount <= '0;
    end else if (enS1 && isClip && (clipCount != '1)) begin
      clipCount <= clipCount + CLIP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sample_source.sv
// Scoreboard bench for sample_source: stimulus pushes expected samples with
// their due cycle, an independent monitor pops and compares on dataValid.
module tb_sample_source;
  import capture_pkg::*;

  localparam int W = 10;

  logic         clock = 1'b0;
  logic         nReset = 1'b0;
  logic [W-1:0] adcDatabus = 10'd512;
  logic [1:0]   mode = 2'd0;
  logic         enable = 1'b0;
  logic [W-1:0] constValue = '0;
  logic         clipClear = 1'b0;
  logic [W-1:0] dataOut;
  logic         dataValid, syncFlag;
  logic [3:0]   clipCount;

  typedef struct {
    logic [W-1:0] data;
    logic         sync;
    int           cyc;
  } expT;

  expT          sbq[$];
  expT          mon;
  int           cycCnt = 0;
  int           checks = 0;
  int           fails = 0;
  logic [W-1:0] lastData = '0;
  logic [W-1:0] lfsrModel;

  sample_source #(
    .DATA_WIDTH (W),
    .RAMP_MAX   (1020),
    .LFSR_TAPS  (10'h240),
    .CLIP_CNT_W (4)
  ) dut (
    .clock       (clock),
    .nReset      (nReset),
    .adc_databus (adcDatabus),
    .mode        (mode),
    .enable      (enable),
    .constValue  (constValue),
    .clipClear   (clipClear),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .syncFlag    (syncFlag),
    .clipCount   (clipCount)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycCnt <= cycCnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycCnt);
    end
  endtask

  always @(negedge clock) begin
    if (nReset) begin
      if (dataValid) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpectedValid: got dataOut=%0h at cycle %0d expected no sample", dataOut, cycCnt);
        end else begin
          mon = sbq.pop_front();
          check("dataOut", dataOut, mon.data);
          check("syncFlag", syncFlag, mon.sync);
          check("latency", cycCnt, mon.cyc);
        end
        lastData = dataOut;
      end else begin
        check("holdOut", dataOut, lastData);
      end
    end
  end

  function automatic logic [W-1:0] lfsrStep(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & 10'h240)};
  endfunction

  task automatic drive(input logic [1:0] m, input logic e, input logic [W-1:0] adc,
                       input logic [W-1:0] cv, input logic clr,
                       input logic [W-1:0] expData, input logic expSync);
    expT x;
    @(posedge clock);
    #1;
    mode = m;
    enable = e;
    adcDatabus = adc;
    constValue = cv;
    clipClear = clr;
    if (e) begin
      x.data = expData;
      x.sync = expSync;
      x.cyc  = cycCnt + 2;
      sbq.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mode, 1'b0, 10'd512, constValue, 1'b0, '0, 1'b0);
  endtask

  task automatic clipTriple(input logic firstSync);
    drive(MODE_ADC, 1'b1, 10'd0,    '0, 1'b0, 10'd0,    firstSync);
    drive(MODE_ADC, 1'b1, 10'h3FF,  '0, 1'b0, 10'h3FF,  1'b0);
    drive(MODE_ADC, 1'b1, 10'd512,  '0, 1'b0, 10'd512,  1'b0);
  endtask

  initial begin
    #12;
    check("rstDataOut", dataOut, 0);
    check("rstValid", dataValid, 0);
    check("rstSync", syncFlag, 0);
    check("rstClip", clipCount, 0);
    nReset = 1'b1;

    // ramp 0..1020 then wrap to 0,1,2,3
    for (int i = 0; i <= 1024; i++) begin
      int v;
      v = (i <= 1020) ? i : i - 1021;
      drive(MODE_RAMP, 1'b1, 10'd512, '0, 1'b0, W'(v), (i == 0) || (i == 1021));
    end
    // enable toggling: one step per enabled clock
    for (int i = 0; i < 8; i++)
      drive(MODE_RAMP, (i % 2) == 0, 10'd512, '0, 1'b0, W'(4 + i / 2), 1'b0);
    for (int v = 8; v <= 500; v++)
      drive(MODE_RAMP, 1'b1, 10'd512, '0, 1'b0, W'(v), 1'b0);

    drive(MODE_ADC,  1'b1, 10'h155, '0, 1'b0, 10'h155, 1'b1);
    drive(MODE_ADC,  1'b1, 10'h0AA, '0, 1'b0, 10'h0AA, 1'b0);
    drive(MODE_RAMP, 1'b1, 10'd512, '0, 1'b0, 10'd0,   1'b1);
    drive(MODE_RAMP, 1'b1, 10'd512, '0, 1'b0, 10'd1,   1'b0);
    drive(MODE_RAMP, 1'b1, 10'd512, '0, 1'b0, 10'd2,   1'b0);

    drive(MODE_CONST, 1'b1, 10'd512, 10'h2AA, 1'b0, 10'h2AA, 1'b1);
    drive(MODE_CONST, 1'b1, 10'd512, 10'h2AA, 1'b0, 10'h2AA, 1'b0);
    drive(MODE_CONST, 1'b1, 10'd512, 10'h123, 1'b0, 10'h123, 1'b0);

    // enter LFSR while disabled: sync rides on the first enabled sample
    drive(MODE_LFSR, 1'b0, 10'd512, '0, 1'b0, '0, 1'b0);
    drive(MODE_LFSR, 1'b0, 10'd512, '0, 1'b0, '0, 1'b0);
    lfsrModel = 10'h3FF;
    for (int i = 0; i < 1024; i++) begin
      drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, (i == 1023) ? 10'h3FF : lfsrModel, i == 0);
      lfsrModel = lfsrStep(lfsrModel);
    end
    drive(MODE_ADC,  1'b1, 10'h100, '0, 1'b0, 10'h100, 1'b1);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FF, 1'b1);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FE, 1'b0);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FC, 1'b0);
    idle(3);

    // clip counter saturation and clear priority
    drive(MODE_ADC, 1'b0, 10'd512, '0, 1'b1, '0, 1'b0);
    idle(2);
    check("clipCleared", clipCount, 0);
    clipTriple(1'b1);
    idle(3);
    check("clipTwo", clipCount, 2);
    for (int i = 0; i < 7; i++) clipTriple(1'b0);
    idle(3);
    check("clipSaturate", clipCount, 15);
    drive(MODE_ADC, 1'b1, 10'd0,   '0, 1'b0, 10'd0, 1'b0);
    drive(MODE_ADC, 1'b0, 10'd512, '0, 1'b1, '0,    1'b0);
    idle(3);
    check("clipClearWins", clipCount, 0);
    drive(MODE_ADC, 1'b1, 10'h3FF, '0, 1'b0, 10'h3FF, 1'b0);
    idle(3);
    check("clipOne", clipCount, 1);

    // reset in the middle of an LFSR run
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FF, 1'b1);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FE, 1'b0);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FC, 1'b0);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3F8, 1'b0);
    @(posedge clock);
    #2;
    nReset = 1'b0;
    enable = 1'b0;
    #1;
    check("midRstDataOut", dataOut, 0);
    check("midRstValid", dataValid, 0);
    check("midRstSync", syncFlag, 0);
    check("midRstClip", clipCount, 0);
    sbq.delete();
    lastData = '0;
    @(posedge clock);
    #3;
    nReset = 1'b1;
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FF, 1'b1);
    drive(MODE_LFSR, 1'b1, 10'd512, '0, 1'b0, 10'h3FE, 1'b0);
    idle(4);

    check("queueDrained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
